// File: rtl/spm_result_tx_pkg.sv
// Shared types and constants for the SPM result framer.
package spm_result_tx_pkg;

  localparam int SAMPLE_W = 16;
  localparam int BYTE_W   = 8;

  localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [BYTE_W-1:0]   byte_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_LEN    = 3'd2,
    ST_WAIT_S = 3'd3,
    ST_HI     = 3'd4,
    ST_LO     = 3'd5,
    ST_CSUM   = 3'd6
  } state_e;

  // States that present a byte to the uart write port.
  function automatic logic is_emit_state(input state_e s);
    return (s == ST_HDR) || (s == ST_LEN) || (s == ST_HI) ||
           (s == ST_LO)  || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/spm_result_tx_if.sv
// Sample input handshake plus uart transmit-FIFO write port.
// master = sample producer / FIFO side, slave = the framer.
interface spm_result_tx_if;
  import spm_result_tx_pkg::*;

  sample_t sample_in;
  logic    sample_valid;
  logic    sample_ready;
  logic    tx_full;
  byte_t   tx_data;
  logic    write_tx_data;

  modport master (
    output sample_in, sample_valid, tx_full,
    input  sample_ready, tx_data, write_tx_data
  );

  modport slave (
    input  sample_in, sample_valid, tx_full,
    output sample_ready, tx_data, write_tx_data
  );

endinterface

// File: rtl/spm_result_tx.sv
// Frames FRAME_LEN 16-bit samples as HEADER, LEN, hi/lo bytes, XOR checksum into the uart TX FIFO.
// First byte 1 cycle after a pending sample in IDLE; tx_full or enable=0 hold the current byte.
module spm_result_tx
  import spm_result_tx_pkg::*;
#(
  parameter int    FRAME_LEN = 8,
  parameter byte_t HEADER    = HEADER_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  spm_result_tx_if.slave    io,
  output logic              busy,
  output logic              frame_done
);

  localparam byte_t LEN_BYTE = byte_t'(FRAME_LEN);

  state_e  state_q, state_d;
  byte_t   count_q, count_d;
  byte_t   csum_q, csum_d;
  sample_t sample_q, sample_d;
  logic    frame_done_q, frame_done_d;

  logic    emit;
  logic    wr_en;
  byte_t   tx_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      csum_q       <= '0;
      sample_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      csum_q       <= csum_d;
      sample_q     <= sample_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Every transition out of a byte state is gated by wr_en, so a byte is
  // written exactly once no matter how long tx_full or enable stall it.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    csum_d       = csum_q;
    sample_d     = sample_q;
    frame_done_d = frame_done_q;
    if (enable) begin
      frame_done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (io.sample_valid) state_d = ST_HDR;
        end
        ST_HDR: begin
          if (wr_en) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (wr_en) begin
            csum_d  = LEN_BYTE;
            state_d = ST_WAIT_S;
          end
        end
        ST_WAIT_S: begin
          if (io.sample_valid) begin
            sample_d = io.sample_in;
            state_d  = ST_HI;
          end
        end
        ST_HI: begin
          if (wr_en) begin
            csum_d  = csum_q ^ sample_q[15:8];
            state_d = ST_LO;
          end
        end
        ST_LO: begin
          if (wr_en) begin
            csum_d  = csum_q ^ sample_q[7:0];
            count_d = count_q + 8'd1;
            state_d = ((count_q + 8'd1) == LEN_BYTE) ? ST_CSUM : ST_WAIT_S;
          end
        end
        ST_CSUM: begin
          if (wr_en) begin
            count_d      = '0;
            csum_d       = '0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_byte = '0;
    case (state_q)
      ST_HDR:  tx_byte = HEADER;
      ST_LEN:  tx_byte = LEN_BYTE;
      ST_HI:   tx_byte = sample_q[15:8];
      ST_LO:   tx_byte = sample_q[7:0];
      ST_CSUM: tx_byte = csum_q;
      default: tx_byte = '0;
    endcase
    emit             = is_emit_state(state_q);
    wr_en            = emit & enable & ~io.tx_full;
    io.write_tx_data = wr_en;
    io.tx_data       = tx_byte;
    io.sample_ready  = (state_q == ST_WAIT_S) & enable;
    busy             = (state_q != ST_IDLE);
    frame_done       = frame_done_q;
  end

endmodule

// File: tb/tb_spm_result_tx.sv
// Bench for spm_result_tx: three instances (FRAME_LEN 8, 2, 1) driven by table vectors,
// hand-written stall/reset sequences and a randomized run against a frame-level model.
module tb_spm_result_tx;

  logic       clk;
  logic       reset;
  logic       en_man;
  logic       enable;
  logic       rnd_on;
  logic       rnd_dis;
  logic [2:0] rnd_full;
  logic [2:0] full_man;
  logic [2:0] s_vld;
  logic [15:0] s_in [3];
  logic [2:0] rdy, wr, busy, fd;
  logic [7:0] txd [3];

  int checks = 0;
  int errors = 0;

  localparam int CAPN = 4096;
  logic [7:0] cap [3][CAPN];
  int         cap_n [3] = '{0, 0, 0};
  int         fd_n  [3] = '{0, 0, 0};
  logic [2:0] fd_prev = 3'b000;

  int         fl_of [3] = '{8, 2, 1};
  logic [15:0] smp [8];
  logic [7:0]  exp_b [64];
  int          exp_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign enable = en_man & ~(rnd_on & rnd_dis);

  always @(posedge clk) begin
    #1;
    rnd_full = 3'($urandom) & 3'($urandom);
    rnd_dis  = ($urandom_range(0, 7) == 0);
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int FL = (g == 0) ? 8 : (g == 1) ? 2 : 1;
    spm_result_tx_if bus ();
    assign bus.sample_in    = s_in[g];
    assign bus.sample_valid = s_vld[g];
    assign bus.tx_full      = full_man[g] | (rnd_on & rnd_full[g]);
    assign rdy[g]           = bus.sample_ready;
    assign txd[g]           = bus.tx_data;
    assign wr[g]            = bus.write_tx_data;
    spm_result_tx #(.FRAME_LEN(FL), .HEADER(8'hA5)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .io         (bus.slave),
      .busy       (busy[g]),
      .frame_done (fd[g])
    );
  end

  // Byte capture and frame_done rising-edge count, sampled mid-cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (wr[g]) begin
        if (cap_n[g] < CAPN) cap[g][cap_n[g]] = txd[g];
        cap_n[g] = cap_n[g] + 1;
      end
      if (fd[g] && !fd_prev[g]) fd_n[g] = fd_n[g] + 1;
      fd_prev[g] = fd[g];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int g, input logic [15:0] v);
    int t;
    if (rnd_on) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_in[g]  = v;
    s_vld[g] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!rdy[g] && t < 3000);
    chk($sformatf("accept_g%0d", g), 32'(rdy[g]), 32'd1);
    @(posedge clk); #1;
    s_vld[g] = 1'b0;
  endtask

  task automatic finish_frame(input int g, input int fdb, input string name);
    int t;
    t = 0;
    while (!fd[g] && t < 3000) begin @(negedge clk); t++; end
    chk({name, "_done_seen"}, 32'(fd[g]), 32'd1);
    @(negedge clk);
    chk({name, "_done_count"}, 32'(fd_n[g] - fdb), 32'd1);
    chk({name, "_busy_after"}, 32'(busy[g]), 32'd0);
    if (!rnd_on) chk({name, "_done_width"}, 32'(fd[g]), 32'd0);
  endtask

  task automatic check_stream(input int g, input int base, input string name);
    int n, m;
    n = cap_n[g] - base;
    chk({name, "_nbytes"}, 32'(n), 32'(exp_n));
    m = (n < exp_n) ? n : exp_n;
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_byte%0d", name, i), 32'(cap[g][base + i]), 32'(exp_b[i]));
  endtask

  // Reference frame built straight from the byte-order rules.
  task automatic build_expected(input int len, input int n);
    logic [7:0] x;
    exp_n = 0;
    exp_b[exp_n] = 8'hA5;    exp_n++;
    exp_b[exp_n] = 8'(len);  exp_n++;
    x = 8'(len);
    for (int i = 0; i < n; i++) begin
      exp_b[exp_n] = smp[i][15:8]; exp_n++;
      exp_b[exp_n] = smp[i][7:0];  exp_n++;
      x = x ^ smp[i][15:8] ^ smp[i][7:0];
    end
    exp_b[exp_n] = x; exp_n++;
  endtask

  task automatic run_frame(input int g, input int n, output int base, output int fdb, input string name);
    base = cap_n[g];
    fdb  = fd_n[g];
    for (int i = 0; i < n; i++) push(g, smp[i]);
    finish_frame(g, fdb, name);
  endtask

  typedef struct {
    int           g;
    int           n;
    logic [127:0] s;
    logic [151:0] e;
    int           ne;
    string        name;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int base, fdb;
    reset = 1'b1; en_man = 1'b1; rnd_on = 1'b0; full_man = 3'b000; s_vld = 3'b000;
    for (int g = 0; g < 3; g++) s_in[g] = 16'h0;

    vecs[0] = '{1, 2, {16'h0000, 16'h00FF, 96'h0}, {56'hA5_02_00_00_00_FF_FD, 96'h0}, 7, "len2_zero_ff"};
    vecs[1] = '{0, 8, 128'h0001_0002_0003_0004_0005_0006_0007_0008,
                152'hA5_08_0001_0002_0003_0004_0005_0006_0007_0008_00, 19, "len8_ramp"};
    vecs[2] = '{1, 2, {16'h1234, 16'hABCD, 96'h0}, {56'hA5_02_12_34_AB_CD_42, 96'h0}, 7, "len2_basic"};
    vecs[3] = '{2, 1, {16'hFFFF, 112'h0}, {40'hA5_01_FF_FF_01, 112'h0}, 5, "len1_ffff"};

    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_busy_g%0d", g), 32'(busy[g]), 32'd0);
      chk($sformatf("rst_wr_g%0d", g),   32'(wr[g]),   32'd0);
      chk($sformatf("rst_txd_g%0d", g),  32'(txd[g]),  32'd0);
      chk($sformatf("rst_rdy_g%0d", g),  32'(rdy[g]),  32'd0);
      chk($sformatf("rst_fd_g%0d", g),   32'(fd[g]),   32'd0);
    end
    @(posedge clk); #1;

    // Reset one cycle after the AB write abandons the frame without a checksum.
    base = cap_n[1]; fdb = fd_n[1];
    push(1, 16'h1234);
    push(1, 16'hABCD);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy[1]), 32'd0);
    chk("midrst_wr",   32'(wr[1]),   32'd0);
    repeat (5) @(negedge clk);
    chk("midrst_no_done", 32'(fd_n[1] - fdb), 32'd0);
    exp_n = 6;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h02; exp_b[2] = 8'h12;
    exp_b[3] = 8'h34; exp_b[4] = 8'hAB; exp_b[5] = 8'hCD;
    check_stream(1, base, "midrst");
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].n; i++) smp[i] = vecs[v].s[127 - 16*i -: 16];
      run_frame(vecs[v].g, vecs[v].n, base, fdb, vecs[v].name);
      exp_n = vecs[v].ne;
      for (int i = 0; i < exp_n; i++) exp_b[i] = vecs[v].e[151 - 8*i -: 8];
      check_stream(vecs[v].g, base, vecs[v].name);
      @(posedge clk); #1;
    end

    // tx_full held for 20 cycles in LO of the first sample.
    smp[0] = 16'h1234; smp[1] = 16'hABCD;
    build_expected(2, 2);
    base = cap_n[1]; fdb = fd_n[1];
    push(1, 16'h1234);
    @(posedge clk); #1;
    full_man[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("full_stall_wr", 32'(wr[1]), 32'd0);
      chk("full_stall_busy", 32'(busy[1]), 32'd1);
    end
    @(posedge clk); #1;
    full_man[1] = 1'b0;
    push(1, 16'hABCD);
    finish_frame(1, fdb, "full_stall");
    check_stream(1, base, "full_stall");
    @(posedge clk); #1;

    // enable low for 10 cycles in WAIT_S with a sample pending.
    base = cap_n[1]; fdb = fd_n[1];
    push(1, 16'h1234);
    @(posedge clk); #1;
    @(posedge clk); #1;
    en_man = 1'b0; s_in[1] = 16'hABCD; s_vld[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("dis_rdy",  32'(rdy[1]),  32'd0);
      chk("dis_wr",   32'(wr[1]),   32'd0);
      chk("dis_busy", 32'(busy[1]), 32'd1);
    end
    @(posedge clk); #1;
    en_man = 1'b1;
    @(negedge clk);
    chk("reen_rdy", 32'(rdy[1]), 32'd1);
    @(posedge clk); #1;
    s_vld[1] = 1'b0;
    finish_frame(1, fdb, "dis_stall");
    check_stream(1, base, "dis_stall");
    @(posedge clk); #1;

    // FRAME_LEN=1: valid withdrawn after starting the frame, re-asserted 5 cycles after LEN.
    base = cap_n[2]; fdb = fd_n[2];
    s_in[2] = 16'hFFFF; s_vld[2] = 1'b1;
    @(posedge clk); #1;
    s_vld[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      chk("late_rdy", 32'(rdy[2]), 32'd1);
      @(posedge clk); #1;
    end
    push(2, 16'hFFFF);
    finish_frame(2, fdb, "late_valid");
    smp[0] = 16'hFFFF;
    build_expected(1, 1);
    check_stream(2, base, "late_valid");
    @(posedge clk); #1;

    // Random samples with random tx_full and enable stalls.
    rnd_on = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int g;
      g = k % 3;
      for (int i = 0; i < fl_of[g]; i++) smp[i] = 16'($urandom);
      run_frame(g, fl_of[g], base, fdb, $sformatf("rand%0d", k));
      build_expected(fl_of[g], fl_of[g]);
      check_stream(g, base, $sformatf("rand%0d", k));
    end
    rnd_on = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
